// File: rtl/band_mixer.sv
// Band mixer: snapshots eight filter-bank band samples, weights each by a
// programmable Q2.14 gain with one shared multiplier, then rounds and saturates the sum.
module band_mixer #(
  parameter int          DW    = 16,
  parameter int          GW    = 16,
  parameter int          ACCW  = 35,
  parameter logic [GW-1:0] GINIT = 16'h4000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bands_valid,
  input  logic [DW-1:0] band0,
  input  logic [DW-1:0] band1,
  input  logic [DW-1:0] band2,
  input  logic [DW-1:0] band3,
  input  logic [DW-1:0] band4,
  input  logic [DW-1:0] band5,
  input  logic [DW-1:0] band6,
  input  logic [DW-1:0] band7,
  input  logic          gain_we,
  input  logic [2:0]    gain_addr,
  input  logic [GW-1:0] gain_wdata,
  output logic          busy,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          sat,
  output logic          overrun
);

  localparam int PW   = DW + GW;
  localparam int MAXI = (1 << (DW - 1)) - 1;
  localparam int MINI = -(1 << (DW - 1));
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(MAXI);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(MINI);
  localparam logic signed [ACCW-1:0] RND  = ACCW'(1 << 13);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DW-1:0]   r_snap [8];
  logic signed [GW-1:0]   r_gain [8];
  logic signed [PW-1:0]   r_prod;
  logic signed [ACCW-1:0] r_acc;
  logic [2:0]             r_idx;
  logic [DW-1:0]          r_dout;
  logic                   r_doutValid;
  logic                   r_sat;
  logic                   r_overrun;
  logic                   r_busy;

  logic signed [PW-1:0]   w_snapExt;
  logic signed [PW-1:0]   w_gainExt;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_prodExt;
  logic signed [ACCW-1:0] w_accSum;
  logic signed [ACCW-1:0] w_round;
  logic signed [ACCW-1:0] w_shift;
  logic                   w_clipHi;
  logic                   w_clipLo;
  logic [DW-1:0]          w_result;
  logic                   w_overrun;

  // Operands are sign-extended to full product width so the multiply is done at 32 bits.
  assign w_snapExt = {{GW{r_snap[r_idx][DW-1]}}, r_snap[r_idx]};
  assign w_gainExt = {{DW{r_gain[r_idx][GW-1]}}, r_gain[r_idx]};
  assign w_prod    = w_snapExt * w_gainExt;
  assign w_prodExt = {{(ACCW - PW){r_prod[PW-1]}}, r_prod};
  assign w_accSum  = r_acc + w_prodExt;

  assign w_round   = r_acc + RND;
  assign w_shift   = w_round >>> 14;
  assign w_clipHi  = (w_shift > MAXV);
  assign w_clipLo  = (w_shift < MINV);
  assign w_result  = w_clipHi ? DW'(MAXI) :
                     w_clipLo ? DW'(MINI) : w_shift[DW-1:0];

  assign w_overrun = bands_valid && (r_state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bands_valid) w_next = MAC;
      MAC:     if (r_idx == 3'd7) w_next = DRAIN;
      DRAIN:   w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Gain writes land on the same edge a product may be issued; the product sees the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_gain[i] <= GINIT;
    end else if (gain_we) begin
      r_gain[gain_addr] <= gain_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_snap[i] <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_doutValid <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= w_overrun;
      r_busy      <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (bands_valid) begin
            r_snap[0] <= band0;
            r_snap[1] <= band1;
            r_snap[2] <= band2;
            r_snap[3] <= band3;
            r_snap[4] <= band4;
            r_snap[5] <= band5;
            r_snap[6] <= band6;
            r_snap[7] <= band7;
            r_acc     <= '0;
            r_prod    <= '0;
            r_idx     <= '0;
          end
        end
        MAC: begin
          r_prod <= w_prod;
          r_acc  <= w_accSum;
          r_idx  <= r_idx + 3'd1;
        end
        DRAIN: begin
          r_acc <= w_accSum;
        end
        OUT: begin
          r_dout      <= w_result;
          r_doutValid <= 1'b1;
          r_sat       <= w_clipHi | w_clipLo;
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign dout       = r_dout;
  assign dout_valid = r_doutValid;
  assign sat        = r_sat;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: directed scenarios plus randomized mixes
// compared against an integer-arithmetic reference of the weighted sum.
module tb_band_mixer;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              bands_valid = 1'b0;
  logic signed [15:0] tbBands [8];
  logic              gain_we = 1'b0;
  logic [2:0]        gain_addr = 3'd0;
  logic signed [15:0] gain_wdata = 16'sd0;
  logic              busy;
  logic signed [15:0] dout;
  logic              dout_valid;
  logic              sat;
  logic              overrun;

  int     modelGain [8];
  int     checkCount = 0;
  int     passCount  = 0;
  int     lat;
  int     validCount;
  longint dOut;
  longint sOut;
  longint expSum;

  band_mixer dut (
    .clock(clock), .reset(reset), .bands_valid(bands_valid),
    .band0(tbBands[0]), .band1(tbBands[1]), .band2(tbBands[2]), .band3(tbBands[3]),
    .band4(tbBands[4]), .band5(tbBands[5]), .band6(tbBands[6]), .band7(tbBands[7]),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_wdata(gain_wdata),
    .busy(busy), .dout(dout), .dout_valid(dout_valid), .sat(sat), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Reference: exact weighted sum, round half up by 2^-14, clip to 16-bit signed.
  function automatic longint refMix(output bit clipped);
    longint acc = 0;
    longint r;
    for (int i = 0; i < 8; i++) acc += longint'(tbBands[i]) * longint'(modelGain[i]);
    r = (acc + 8192) >>> 14;
    clipped = 1'b0;
    if (r > 32767)  begin r = 32767;  clipped = 1'b1; end
    if (r < -32768) begin r = -32768; clipped = 1'b1; end
    return r;
  endfunction

  task automatic writeGain(input int addr, input logic signed [15:0] val);
    gain_we    = 1'b1;
    gain_addr  = addr[2:0];
    gain_wdata = val;
    @(negedge clock);
    gain_we = 1'b0;
    modelGain[addr] = int'(val);
  endtask

  task automatic setAllGains(input logic signed [15:0] val);
    for (int i = 0; i < 8; i++) writeGain(i, val);
  endtask

  task automatic setAllBands(input logic signed [15:0] val);
    for (int i = 0; i < 8; i++) tbBands[i] = val;
  endtask

  task automatic applyStimulus(output int latency, output longint dv, output longint sv);
    bands_valid = 1'b1;
    @(negedge clock);
    bands_valid = 1'b0;
    latency = -1;
    dv = 0;
    sv = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if (cyc == 1) checkOutput("busyMid", longint'(busy), 1);
      if (dout_valid) begin
        latency = cyc;
        dv = longint'(dout);
        sv = longint'(sat);
        checkOutput("busyDone", longint'(busy), 0);
        break;
      end
    end
  endtask

  task automatic runCase(input string tag);
    bit     expSat;
    longint expDout;
    int     l;
    longint d;
    longint s;
    expDout = refMix(expSat);
    applyStimulus(l, d, s);
    checkOutput({tag, "_lat"}, longint'(l), 10);
    checkOutput({tag, "_dout"}, d, expDout);
    checkOutput({tag, "_sat"}, s, longint'(expSat));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      modelGain[i] = 16384;
      tbBands[i]   = 16'sd0;
    end

    // Reset state
    @(negedge clock);
    @(negedge clock);
    checkOutput("rstDout", longint'(dout), 0);
    checkOutput("rstValid", longint'(dout_valid), 0);
    checkOutput("rstBusy", longint'(busy), 0);
    checkOutput("rstSat", longint'(sat), 0);
    checkOutput("rstOverrun", longint'(overrun), 0);
    reset = 1'b1;
    @(negedge clock);

    // Test 1: default gains, all bands 1000
    setAllBands(16'sd1000);
    runCase("t1");

    // Test 2: only band3 weighted by 0.5
    setAllGains(16'sd0);
    writeGain(3, 16'sh2000);
    setAllBands(16'sd5000);
    tbBands[3] = -16'sd1001;
    runCase("t2");
    checkOutput("t2Lit", dOut, 0);

    // Test 3: positive and negative saturation
    setAllGains(16'sh7FFF);
    setAllBands(16'sd32767);
    runCase("t3pos");
    setAllBands(-16'sd32768);
    runCase("t3neg");

    // Test 4: second strobe while busy is dropped
    setAllGains(16'sh4000);
    for (int i = 0; i < 8; i++) tbBands[i] = 16'(100 * (i + 1));
    begin
      bit dummy;
      expSum = refMix(dummy);
    end
    bands_valid = 1'b1;
    @(negedge clock);
    bands_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    setAllBands(16'sd2000);
    bands_valid = 1'b1;
    @(negedge clock);
    bands_valid = 1'b0;
    checkOutput("t4OverrunHi", longint'(overrun), 1);
    validCount = 0;
    dOut = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      if (cyc == 0) checkOutput("t4OverrunLo", longint'(overrun), 0);
      if (dout_valid) begin
        validCount++;
        dOut = longint'(dout);
      end
    end
    checkOutput("t4Count", longint'(validCount), 1);
    checkOutput("t4Dout", dOut, expSum);

    // Test 5: reset mid-computation
    setAllBands(16'sd1234);
    bands_valid = 1'b1;
    @(negedge clock);
    bands_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("t5Dout", longint'(dout), 0);
    checkOutput("t5Busy", longint'(busy), 0);
    checkOutput("t5Valid", longint'(dout_valid), 0);
    @(negedge clock);
    reset = 1'b1;
    validCount = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clock);
      if (dout_valid) validCount++;
    end
    checkOutput("t5NoValid", longint'(validCount), 0);
    for (int i = 0; i < 8; i++) modelGain[i] = 16384;
    setAllBands(16'sd1000);
    runCase("t5Gains");

    // Test 6: gain7 cleared at E3, before band7's product is issued
    for (int i = 0; i < 8; i++) tbBands[i] = 16'(300 * i - 700);
    expSum = 0;
    for (int i = 0; i < 7; i++) expSum += longint'(tbBands[i]);
    bands_valid = 1'b1;
    @(negedge clock);
    bands_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    gain_we    = 1'b1;
    gain_addr  = 3'd7;
    gain_wdata = 16'sd0;
    @(negedge clock);
    gain_we = 1'b0;
    modelGain[7] = 0;
    lat = -1;
    dOut = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      if (dout_valid) begin
        lat = cyc + 3;
        dOut = longint'(dout);
        break;
      end
    end
    checkOutput("t6Lat", longint'(lat), 10);
    checkOutput("t6Dout", dOut, expSum);

    // Randomized mixes
    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = int'($urandom_range(0, 8));
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 3) == 0)
          writeGain(int'($urandom_range(0, 7)), 16'sh7FFF);
        else
          writeGain(int'($urandom_range(0, 7)), 16'($urandom));
      end
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 4) == 0) tbBands[i] = ($urandom_range(0, 1) == 0) ? 16'sd32767 : -16'sd32768;
        else tbBands[i] = 16'($urandom);
      end
      runCase("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
